// File: rtl/alu_arb_seq_if.sv
// Command/response bundle for alu_arb_seq: two packed requesters in, one shared response out.
// The master modport is the requester/sink side; slave is the ALU itself.
interface alu_arb_seq_if;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [5:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_y;
   logic       rsp_c;
   logic       rsp_z;
   logic       rsp_err;
   logic       busy;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_c, rsp_z, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_y, rsp_c, rsp_z, rsp_err, busy
   );
endinterface

// File: rtl/alu_arb_seq.sv
// Two-requester round-robin 4-bit ALU with a single command in flight.
// Define ALU_ARB_SEQ_MUL_EN to build the 4-cycle shift-add multiplier; otherwise opcode 110 is illegal.
module alu_arb_seq (
   input logic         clk,
   input logic         rst,
   alu_arb_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   state_t     state;
   logic       lastGrant;
   logic       grantIdx;
   logic       grantValid;
   logic [2:0] selOp;
   logic [3:0] selA;
   logic [3:0] selB;

   logic [2:0] opReg;
   logic [3:0] aReg;
   logic [3:0] bReg;
   logic       idReg;

   logic       rspValid;
   logic [7:0] rspY;
   logic       rspC;
   logic       rspZ;
   logic       rspErr;
   logic       rspId;

   logic [7:0] aluY;
   logic       aluC;
   logic       aluErr;
   logic [4:0] aluWide;

`ifdef ALU_ARB_SEQ_MUL_EN
   logic [1:0] mulCnt;
   logic [7:0] mulAcc;
   logic [7:0] mulMcand;
   logic [3:0] mulMplier;
   logic [7:0] mulSum;

   // One partial product per cycle: multiplicand walks left, multiplier walks right.
   assign mulSum = mulAcc + (mulMplier[0] ? mulMcand : 8'h00);
`endif

   // Contention goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      grantIdx = 1'b0;
      if (bus.req_valid == 2'b11) begin
         grantIdx = ~lastGrant;
      end else if (bus.req_valid[1]) begin
         grantIdx = 1'b1;
      end
   end

   assign grantValid    = (state == IDLE) && !rst && (bus.req_valid != 2'b00);
   assign bus.req_ready = grantValid ? (grantIdx ? 2'b10 : 2'b01) : 2'b00;

   assign selOp = grantIdx ? bus.req_op[5:3] : bus.req_op[2:0];
   assign selA  = grantIdx ? bus.req_a[7:4]  : bus.req_a[3:0];
   assign selB  = grantIdx ? bus.req_b[7:4]  : bus.req_b[3:0];

   // Single-cycle ops; anything not listed (reserved, or MUL when not built) is an error.
   always_comb begin
      aluY    = 8'h00;
      aluC    = 1'b0;
      aluErr  = 1'b0;
      aluWide = 5'd0;
      case (opReg)
         3'b000: begin
            aluWide = {1'b0, aReg} + {1'b0, bReg};
            aluY    = {4'h0, aluWide[3:0]};
            aluC    = aluWide[4];
         end
         3'b001: begin
            aluWide = {1'b0, aReg} - {1'b0, bReg};
            aluY    = {4'h0, aluWide[3:0]};
            aluC    = aluWide[4];
         end
         3'b010:  aluY = {4'h0, aReg & bReg};
         3'b011:  aluY = {4'h0, aReg | bReg};
         3'b100:  aluY = {4'h0, aReg ^ bReg};
         3'b101:  aluY = {4'h0, ~(aReg | bReg)};
         default: aluErr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lastGrant <= 1'b1;
         opReg     <= 3'd0;
         aReg      <= 4'h0;
         bReg      <= 4'h0;
         idReg     <= 1'b0;
         rspValid  <= 1'b0;
         rspY      <= 8'h00;
         rspC      <= 1'b0;
         rspZ      <= 1'b0;
         rspErr    <= 1'b0;
         rspId     <= 1'b0;
`ifdef ALU_ARB_SEQ_MUL_EN
         mulCnt    <= 2'd0;
         mulAcc    <= 8'h00;
         mulMcand  <= 8'h00;
         mulMplier <= 4'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grantValid) begin
                  lastGrant <= grantIdx;
                  idReg     <= grantIdx;
                  opReg     <= selOp;
                  aReg      <= selA;
                  bReg      <= selB;
`ifdef ALU_ARB_SEQ_MUL_EN
                  mulCnt    <= 2'd0;
                  mulAcc    <= 8'h00;
                  mulMcand  <= {4'h0, selA};
                  mulMplier <= selB;
                  state     <= (selOp == 3'b110) ? MUL : EXEC;
`else
                  state     <= EXEC;
`endif
               end
            end
            EXEC: begin
               rspY     <= aluY;
               rspC     <= aluC;
               rspErr   <= aluErr;
               rspZ     <= (aluY == 8'h00) && !aluErr;
               rspId    <= idReg;
               rspValid <= 1'b1;
               state    <= RESP;
            end
`ifdef ALU_ARB_SEQ_MUL_EN
            MUL: begin
               mulAcc    <= mulSum;
               mulMcand  <= mulMcand << 1;
               mulMplier <= mulMplier >> 1;
               mulCnt    <= mulCnt + 2'd1;
               if (mulCnt == 2'd3) begin
                  rspY     <= mulSum;
                  rspC     <= 1'b0;
                  rspErr   <= 1'b0;
                  rspZ     <= (mulSum == 8'h00);
                  rspId    <= idReg;
                  rspValid <= 1'b1;
                  state    <= RESP;
               end
            end
`endif
            RESP: begin
               if (bus.rsp_ready) begin
                  rspValid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = rspValid;
   assign bus.rsp_y     = rspY;
   assign bus.rsp_c     = rspC;
   assign bus.rsp_z     = rspZ;
   assign bus.rsp_err   = rspErr;
   assign bus.rsp_id    = rspId;
   assign bus.busy      = (state != IDLE);

endmodule
